if_bus_if: RTL and testbench

//  Instruction-fetch bus master; directly upstream of the IF pipeline register.

---
 rtl/if_bus_if_pkg.sv | 21 ++
 rtl/if_bus_if.sv | 179 +++++++++++++++++
 tb/tb_if_bus_if.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_bus_if_pkg.sv
// Shared types and constants for the instruction-fetch bus master.
// Word-granular addressing: 30-bit word address, 32-bit instruction word.
package if_bus_if_pkg;

    localparam int IF_BUS_STATE_W = 2;
    localparam int WORD_ADDR_W    = 30;
    localparam int WORD_DATA_W    = 32;

    // Reset is active-high in this core.
    localparam logic RESET_ENABLE = 1'b1;

    localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

    typedef enum logic [IF_BUS_STATE_W-1:0] {
        IF_IDLE   = 2'd0,
        IF_REQ    = 2'd1,
        IF_ACCESS = 2'd2,
        IF_WAIT   = 2'd3
    } if_bus_state_e;

endpackage

// File: rtl/if_bus_if.sv
// Instruction-fetch bus master: one-cycle SPM path plus a req/grant/ready
// external bus path, with busy back-pressure to pipeline control.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IF_IDLE   | no bus fetch outstanding; SPM hits are served from here
// IF_REQ    | bus_req raised, waiting for bus_grnt
// IF_ACCESS | granted; bus_as pulses with the latched word address
// IF_WAIT   | waiting for bus_rdy; data dropped if the fetch was aborted
module if_bus_if
    import if_bus_if_pkg::*;
#(
    parameter logic [WORD_ADDR_W-1:0] SPM_BASE  = 30'h0000_0000,
    parameter int unsigned            SPM_DEPTH = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [WORD_ADDR_W-1:0] addr_i,
    input  logic                   as_i,
    output logic [WORD_DATA_W-1:0] insn_o,
    output logic                   busy_o,
    output logic [WORD_ADDR_W-1:0] spm_addr_o,
    output logic                   spm_as_o,
    input  logic [WORD_DATA_W-1:0] spm_rd_data_i,
    output logic                   bus_req_o,
    input  logic                   bus_grnt_i,
    output logic [WORD_ADDR_W-1:0] bus_addr_o,
    output logic                   bus_as_o,
    input  logic                   bus_rdy_i,
    input  logic [WORD_DATA_W-1:0] bus_rd_data_i
);

    localparam logic [31:0] SPM_DEPTH_W = 32'(SPM_DEPTH);

    if_bus_state_e          state_q;
    logic                   abort_q;
    logic [WORD_ADDR_W-1:0] addr_q;
    logic [WORD_ADDR_W-1:0] bus_addr_q;
    logic                   bus_as_q;
    logic [WORD_DATA_W-1:0] insn_q;
    logic                   spm_pend_q;

    logic                   rst_act;
    logic [WORD_ADDR_W-1:0] spm_off;
    logic                   spm_hit;
    logic                   fetch_go;
    logic                   start_spm;
    logic                   start_bus;
    logic [WORD_DATA_W-1:0] insn_cur;
    logic                   insn_nop;
    logic                   insn_load;

    assign rst_act = (reset_i == RESET_ENABLE);

    // Offset compare wraps at 30 bits, so a window near the top of the map still decodes.
    assign spm_off = addr_i - SPM_BASE;
    assign spm_hit = ({2'b00, spm_off} < SPM_DEPTH_W);

    assign fetch_go  = (state_q == IF_IDLE) && as_i && !flush_i && !stall_i && !rst_act;
    assign start_spm = fetch_go && spm_hit;
    assign start_bus = fetch_go && !spm_hit;

    assign spm_addr_o = addr_i;
    assign spm_as_o   = start_spm;
    assign bus_addr_o = bus_addr_q;
    assign bus_as_o   = bus_as_q;

    // SPM read data arrives the cycle after the strobe and is shown directly,
    // then folded into insn_q so a following stall keeps it.
    assign insn_cur = spm_pend_q ? spm_rd_data_i : insn_q;
    assign insn_o   = insn_cur;

    always_comb begin
        busy_o    = 1'b0;
        bus_req_o = 1'b0;
        if (!rst_act) begin
            case (state_q)
                IF_IDLE: begin
                    busy_o    = start_bus;
                    bus_req_o = start_bus;
                end
                IF_REQ, IF_ACCESS: begin
                    busy_o    = 1'b1;
                    bus_req_o = 1'b1;
                end
                IF_WAIT: begin
                    busy_o    = !bus_rdy_i;
                    bus_req_o = !bus_rdy_i;
                end
                default: begin
                    busy_o    = 1'b0;
                    bus_req_o = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_act) begin
            state_q    <= IF_IDLE;
            abort_q    <= 1'b0;
            addr_q     <= '0;
            bus_addr_q <= '0;
            bus_as_q   <= 1'b0;
        end else begin
            bus_as_q <= 1'b0;
            case (state_q)
                IF_IDLE: begin
                    if (start_bus) begin
                        addr_q  <= addr_i;
                        state_q <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    // A grant is never abandoned; a flush in the same cycle only marks it aborted.
                    if (bus_grnt_i) begin
                        state_q    <= IF_ACCESS;
                        bus_as_q   <= 1'b1;
                        bus_addr_q <= addr_q;
                        abort_q    <= flush_i;
                    end else if (flush_i) begin
                        state_q <= IF_IDLE;
                    end
                end
                IF_ACCESS: begin
                    state_q <= IF_WAIT;
                    if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                end
                IF_WAIT: begin
                    if (bus_rdy_i) begin
                        state_q <= IF_IDLE;
                        abort_q <= 1'b0;
                    end else if (flush_i) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= IF_IDLE;
            endcase
        end
    end

    always_comb begin
        insn_nop  = 1'b0;
        insn_load = 1'b0;
        case (state_q)
            IF_IDLE: insn_nop = !stall_i && (flush_i || !as_i);
            IF_REQ:  insn_nop = flush_i && !bus_grnt_i;
            IF_WAIT: begin
                insn_nop  = bus_rdy_i && (abort_q || flush_i);
                insn_load = bus_rdy_i && !abort_q && !flush_i;
            end
            default: begin
                insn_nop  = 1'b0;
                insn_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_act) begin
            insn_q     <= ISA_NOP;
            spm_pend_q <= 1'b0;
        end else begin
            spm_pend_q <= start_spm;
            if (insn_nop) begin
                insn_q <= ISA_NOP;
            end else if (insn_load) begin
                insn_q <= bus_rd_data_i;
            end else begin
                insn_q <= insn_cur;
            end
        end
    end

endmodule

// File: tb/tb_if_bus_if.sv
// Directed bench for if_bus_if: SPM and bus models respond to the DUT,
// a monitor compares insn against a queue of expected fetch results.
module tb_if_bus_if;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [29:0] addr_i = '0;
    logic        as_i = 1'b0;
    logic [31:0] insn_o;
    logic        busy_o;
    logic [29:0] spm_addr_o;
    logic        spm_as_o;
    logic [31:0] spm_rd_data_i = 32'h5A5A_5A5A;
    logic        bus_req_o;
    logic        bus_grnt_i = 1'b0;
    logic [29:0] bus_addr_o;
    logic        bus_as_o;
    logic        bus_rdy_i = 1'b0;
    logic [31:0] bus_rd_data_i = 32'h5A5A_5A5A;

    if_bus_if dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .addr_i        (addr_i),
        .as_i          (as_i),
        .insn_o        (insn_o),
        .busy_o        (busy_o),
        .spm_addr_o    (spm_addr_o),
        .spm_as_o      (spm_as_o),
        .spm_rd_data_i (spm_rd_data_i),
        .bus_req_o     (bus_req_o),
        .bus_grnt_i    (bus_grnt_i),
        .bus_addr_o    (bus_addr_o),
        .bus_as_o      (bus_as_o),
        .bus_rdy_i     (bus_rdy_i),
        .bus_rd_data_i (bus_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Model knobs set by the stimulus.
    logic [31:0] spm_word = 32'h0;
    logic [31:0] rd_word = 32'h0;
    int          grant_dly = 0;
    int          rdy_dly = 1;

    // Model / monitor observations.
    int          req_cnt = 0;
    int          rdy_cnt = 0;
    logic        granted = 1'b0;
    int          as_count = 0;
    logic [29:0] last_bus_addr = '0;
    int          busy_run = 0;
    int          last_busy_len = 0;
    int          busy_total = 0;
    logic        prev_spm = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev2_busy = 1'b0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.insn = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (busy_o && k < 50);
        chk({name, "_done"}, {31'b0, busy_o}, 32'h0);
        cyc();
        cyc();
    endtask

    // SPM: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk_i) begin
        spm_rd_data_i <= spm_as_o ? spm_word : 32'h5A5A_5A5A;
    end

    // External bus slave with programmable grant and ready delays.
    always @(posedge clk_i) begin : bus_model
        int nxt;
        if (reset_i) begin
            req_cnt       <= 0;
            granted       <= 1'b0;
            bus_grnt_i    <= 1'b0;
            rdy_cnt       <= 0;
            bus_rdy_i     <= 1'b0;
            bus_rd_data_i <= 32'h5A5A_5A5A;
        end else begin
            if (!bus_req_o) begin
                req_cnt    <= 0;
                granted    <= 1'b0;
                bus_grnt_i <= 1'b0;
            end else if (!granted) begin
                req_cnt <= req_cnt + 1;
                if (req_cnt == grant_dly) begin
                    bus_grnt_i <= 1'b1;
                    granted    <= 1'b1;
                end
            end else begin
                bus_grnt_i <= 1'b0;
            end

            if (bus_as_o) begin
                as_count      <= as_count + 1;
                last_bus_addr <= bus_addr_o;
            end

            bus_rdy_i     <= 1'b0;
            bus_rd_data_i <= 32'h5A5A_5A5A;
            nxt = bus_as_o ? 1 : ((rdy_cnt != 0) ? rdy_cnt + 1 : 0);
            if (nxt != 0 && nxt == rdy_dly) begin
                bus_rdy_i     <= 1'b1;
                bus_rd_data_i <= rd_word;
                rdy_cnt       <= 0;
            end else begin
                rdy_cnt <= nxt;
            end
        end
    end

    // Monitor: a result is due the cycle after an SPM strobe, and one cycle
    // after busy falls (insn register loads on the ready cycle).
    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                prev_spm   = 1'b0;
                prev_busy  = 1'b0;
                prev2_busy = 1'b0;
                busy_run   = 0;
            end else begin
                if (prev_spm || (prev2_busy && !prev_busy)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_unexpected: insn %h presented with no expected entry", insn_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk(mon_e.name, insn_o, mon_e.insn);
                    end
                end
                if (busy_o) begin
                    busy_run++;
                    busy_total++;
                end else if (busy_run != 0) begin
                    last_busy_len = busy_run;
                    busy_run = 0;
                end
                prev2_busy = prev_busy;
                prev_busy  = busy_o;
                prev_spm   = spm_as_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int as_before;
        int busy_before;

        cyc();
        cyc();
        reset_i = 1'b0;
        chk("rst_insn", insn_o, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_bus_req", {31'b0, bus_req_o}, 32'h0);
        chk("rst_bus_addr", {2'b0, bus_addr_o}, 32'h0);
        cyc();

        // Reset while the bus fetch sits in WAIT.
        grant_dly = 0; rdy_dly = 20; rd_word = 32'h7777_7777;
        addr_i = 30'h1000_0200; as_i = 1'b1;
        cyc(); as_i = 1'b0;
        cyc();
        cyc();
        chk("wait_busy", {31'b0, busy_o}, 32'h1);
        reset_i = 1'b1;
        #1;
        chk("rst_wait_req_drop", {30'b0, bus_req_o, busy_o}, 32'h0);
        cyc(); reset_i = 1'b0;
        chk("rstw_insn", insn_o, 32'h0);
        chk("rstw_busy_req_as", {29'b0, busy_o, bus_req_o, bus_as_o}, 32'h0);
        cyc();

        // SPM hit.
        busy_before = busy_total;
        spm_word = 32'hDEAD_BEEF; addr_i = 30'h10; as_i = 1'b1;
        push("spm_hit", 32'hDEAD_BEEF);
        #1;
        chk("spm_strobe", {31'b0, spm_as_o}, 32'h1);
        chk("spm_addr", {2'b0, spm_addr_o}, 32'h10);
        cyc(); as_i = 1'b0;
        cyc();
        chk("as0_nop", insn_o, 32'h0);
        chk("spm_no_busy", busy_total - busy_before, 32'h0);

        // Last SPM word, then first word past the window (bus miss).
        spm_word = 32'h1111_0FFF; addr_i = 30'hFFF; as_i = 1'b1;
        push("spm_last", 32'h1111_0FFF);
        #1;
        chk("spm_last_strobe", {31'b0, spm_as_o}, 32'h1);
        cyc();
        grant_dly = 0; rdy_dly = 1; rd_word = 32'h2222_1000;
        addr_i = 30'h1000;
        push("miss_first", 32'h2222_1000);
        #1;
        chk("miss_first_dec", {29'b0, spm_as_o, bus_req_o, busy_o}, 32'h3);
        cyc(); as_i = 1'b0;
        wait_idle("miss_first");
        chk("min_latency", last_busy_len, 32'd3);

        // Miss with grant after 2 cycles and ready after 3.
        as_before = as_count;
        grant_dly = 2; rdy_dly = 3; rd_word = 32'hA5C3_0F01;
        addr_i = 30'h1000_0000; as_i = 1'b1;
        push("miss_main", 32'hA5C3_0F01);
        cyc(); as_i = 1'b0;
        wait_idle("miss_main");
        chk("miss_as_pulses", as_count - as_before, 32'd1);
        chk("miss_bus_addr", {2'b0, last_bus_addr}, 32'h1000_0000);
        chk("miss_busy_len", last_busy_len, 32'd7);

        // Flush in WAIT; ready arrives two cycles later.
        as_before = as_count;
        grant_dly = 0; rdy_dly = 3; rd_word = 32'h1234_5678;
        addr_i = 30'h2000_0040; as_i = 1'b1;
        push("flush_wait", 32'h0);
        cyc(); as_i = 1'b0;
        cyc();
        cyc(); flush_i = 1'b1;
        cyc(); flush_i = 1'b0;
        wait_idle("flush_wait");
        chk("flush_wait_as", as_count - as_before, 32'd1);
        chk("flush_wait_busy_len", last_busy_len, 32'd5);

        // Flush coinciding with ready.
        grant_dly = 0; rdy_dly = 1; rd_word = 32'h0BAD_F00D;
        addr_i = 30'h2000_0080; as_i = 1'b1;
        push("flush_rdy", 32'h0);
        cyc(); as_i = 1'b0;
        cyc();
        cyc(); flush_i = 1'b1;
        #1;
        chk("flush_rdy_busy", {31'b0, busy_o}, 32'h0);
        cyc(); flush_i = 1'b0;
        cyc();
        cyc();

        // Miss completes under stall; word must be held.
        grant_dly = 1; rdy_dly = 1; rd_word = 32'hCAFE_0001;
        addr_i = 30'h1000_0100; as_i = 1'b1;
        push("stall_miss", 32'hCAFE_0001);
        cyc(); stall_i = 1'b1;
        wait_idle("stall_miss");
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("stall_hold_%0d", i), insn_o, 32'hCAFE_0001);
            chk($sformatf("stall_no_req_%0d", i), {31'b0, bus_req_o}, 32'h0);
        end

        // Stall together with flush: nothing starts, insn held.
        flush_i = 1'b1; addr_i = 30'h20;
        #1;
        chk("stall_flush_idle", {30'b0, spm_as_o, bus_req_o}, 32'h0);
        cyc();
        chk("stall_flush_hold", insn_o, 32'hCAFE_0001);
        stall_i = 1'b0;
        #1;
        chk("flush_idle_idle", {30'b0, spm_as_o, bus_req_o}, 32'h0);
        cyc(); flush_i = 1'b0; as_i = 1'b0;
        chk("flush_idle_nop", insn_o, 32'h0);
        cyc();

        // Flush in REQ before any grant.
        as_before = as_count;
        grant_dly = 10; rdy_dly = 1; rd_word = 32'h3333_3333;
        addr_i = 30'h3000_0000; as_i = 1'b1;
        push("flush_req", 32'h0);
        cyc(); as_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flush_req_held", {31'b0, bus_req_o}, 32'h1);
        cyc(); flush_i = 1'b0;
        chk("flush_req_drop", {30'b0, bus_req_o, busy_o}, 32'h0);
        for (int i = 0; i < 12; i++) cyc();
        chk("flush_req_no_as", as_count - as_before, 32'd0);

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
